// File: rtl/mm_job_sched_pkg.sv
// rtl/mm_job_sched_pkg.sv - shared types, job layout and byte extraction for the mm job scheduler
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT,
    ST_COLLECT,
    ST_RESP,
    ST_GAP
  } state_t;

  localparam int JOB_BYTES = 9;
  localparam int RES_WORDS = 4;
  localparam int RES_W     = 17;
  localparam int JOB_W     = 68;
  localparam int ROT_LSB   = 0;
  localparam int A_LSB     = 4;
  localparam int B_LSB     = 36;

  // b follows a contiguously, so bytes 1..8 are a flat walk starting at A_LSB
  function automatic logic [7:0] job_byte(input logic [JOB_W-1:0] job, input logic [3:0] idx);
    if (idx == 4'd0) begin
      return {4'b0000, job[ROT_LSB +: 4]};
    end
    return job[A_LSB + 8 * (int'(idx) - 1) +: 8];
  endfunction

endpackage

// File: rtl/mm_job_sched_if.sv
// rtl/mm_job_sched_if.sv - requester, engine and result signals of the mm job scheduler
interface mm_job_sched_if;
  import mm_pkg::*;

  logic [1:0]                 req;
  logic [JOB_W-1:0]           job0;
  logic [JOB_W-1:0]           job1;
  logic [1:0]                 gnt;
  logic [7:0]                 eng_in;
  logic                       eng_in_valid;
  logic [RES_W-1:0]           eng_out;
  logic                       eng_out_valid;
  logic                       res_valid;
  logic                       res_ready;
  logic                       res_id;
  logic [RES_W*RES_WORDS-1:0] res_c;
  logic                       busy;
  logic                       err_timeout;

  modport master (
    input  req, job0, job1, eng_out, eng_out_valid, res_ready,
    output gnt, eng_in, eng_in_valid, res_valid, res_id, res_c, busy, err_timeout
  );

  modport slave (
    output req, job0, job1, eng_out, eng_out_valid, res_ready,
    input  gnt, eng_in, eng_in_valid, res_valid, res_id, res_c, busy, err_timeout
  );

endinterface

// File: rtl/mm_job_sched_rr_arb2.sv
// rtl/mm_job_sched_rr_arb2.sv - two-way round-robin picker with registered priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio1;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio1 ? 2'b10 : 2'b01;
    end
  end

  // after granting requester 0, requester 1 gets the next tie and vice versa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio1 <= 1'b0;
    end else if (update && (|grant)) begin
      prio1 <= grant[0];
    end
  end

endmodule

// File: rtl/mm_job_sched.sv
// rtl/mm_job_sched.sv - shares one serial 2x2 matrix-multiply engine between two requesters
module mm_job_sched
  import mm_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int GAP     = 2
) (
  input logic            clk,
  input logic            rst_n,
  mm_job_sched_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  state_t                     state;
  logic [1:0]                 arb_gnt;
  logic                       arb_upd;
  logic [JOB_W-1:0]           job_sel;
  logic [JOB_W-1:0]           job_q;
  logic [3:0]                 byte_idx;
  logic [TW-1:0]              wcnt;
  logic [GW-1:0]              gcnt;
  logic [1:0]                 ccnt;
  logic [RES_W-1:0]           c_buf [0:2];
  logic [1:0]                 gnt_q;
  logic [7:0]                 eng_in_q;
  logic                       eng_in_valid_q;
  logic                       res_valid_q;
  logic                       res_id_q;
  logic [RES_W*RES_WORDS-1:0] res_c_q;
  logic                       busy_q;
  logic                       err_q;

  assign arb_upd = (state == ST_IDLE) && (|bus.req);
  assign job_sel = arb_gnt[1] ? bus.job1 : bus.job0;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req),
    .update (arb_upd),
    .grant  (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      job_q          <= '0;
      byte_idx       <= '0;
      wcnt           <= '0;
      gcnt           <= '0;
      ccnt           <= '0;
      c_buf[0]       <= '0;
      c_buf[1]       <= '0;
      c_buf[2]       <= '0;
      gnt_q          <= '0;
      eng_in_q       <= '0;
      eng_in_valid_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_id_q       <= 1'b0;
      res_c_q        <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      gnt_q <= '0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_q          <= arb_gnt;
            job_q          <= job_sel;
            res_id_q       <= arb_gnt[1];
            eng_in_q       <= job_byte(job_sel, 4'd0);
            eng_in_valid_q <= 1'b1;
            byte_idx       <= 4'd1;
            busy_q         <= 1'b1;
            state          <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (byte_idx == 4'(JOB_BYTES)) begin
            eng_in_q       <= '0;
            eng_in_valid_q <= 1'b0;
            wcnt           <= '0;
            state          <= ST_WAIT;
          end else begin
            eng_in_q <= job_byte(job_q, byte_idx);
            byte_idx <= byte_idx + 4'd1;
          end
        end
        ST_WAIT: begin
          if (bus.eng_out_valid) begin
            c_buf[0] <= bus.eng_out;
            ccnt     <= 2'd1;
            state    <= ST_COLLECT;
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            gcnt  <= '0;
            state <= ST_GAP;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        ST_COLLECT: begin
          // the engine streams all words back-to-back; any hole means the job is lost
          if (!bus.eng_out_valid) begin
            err_q <= 1'b1;
            gcnt  <= '0;
            state <= ST_GAP;
          end else if (ccnt == 2'd3) begin
            res_c_q     <= {bus.eng_out, c_buf[2], c_buf[1], c_buf[0]};
            res_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else begin
            c_buf[ccnt] <= bus.eng_out;
            ccnt        <= ccnt + 2'd1;
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            gcnt        <= '0;
            state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (bus.eng_out_valid) begin
            gcnt <= '0;
          end else if (gcnt == GW'(GAP - 1)) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.eng_in       = eng_in_q;
  assign bus.eng_in_valid = eng_in_valid_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_id       = res_id_q;
  assign bus.res_c        = res_c_q;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_mm_job_sched.sv
// tb/tb_mm_job_sched.sv - directed self-checking bench for mm_job_sched with a behavioural engine
module tb_mm_job_sched;
  import mm_pkg::*;

  localparam int TIMEOUT = 32;
  localparam int GAP     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mm_job_sched_if bus();

  mm_job_sched #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int          eng_mode = 0;
  int          bcnt, dly, oleft, oidx;
  logic [7:0]  ib   [0:8];
  logic [16:0] cres [0:3];
  logic [7:0]  ops  [0:8];

  localparam logic [67:0] C_T1  = {17'd50, 17'd43, 17'd22, 17'd19};
  localparam logic [67:0] C_MAX = {4{17'd130050}};
  localparam logic [67:0] C_ID  = {17'd6, 17'd7, 17'd8, 17'd9};
  localparam logic [67:0] C_X2  = {17'd12, 17'd10, 17'd8, 17'd6};

  // engine: rotate byte ignored, C = A*B, words after a short delay
  // mode 0 = four words, 1 = silent, 2 = only two words
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0; dly = 0; oleft = 0; oidx = 0;
      bus.eng_out_valid = 1'b0;
      bus.eng_out = '0;
    end else begin
      bus.eng_out_valid = 1'b0;
      bus.eng_out = '0;
      if (oleft > 0) begin
        bus.eng_out_valid = 1'b1;
        bus.eng_out = cres[oidx];
        oidx++;
        oleft--;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          oleft = (eng_mode == 1) ? 0 : (eng_mode == 2) ? 2 : 4;
          oidx  = 0;
        end
      end
      if (bus.eng_in_valid) begin
        ib[bcnt] = bus.eng_in;
        bcnt++;
        if (bcnt == 9) begin
          bcnt = 0;
          dly  = 3;
          cres[0] = 17'(ib[1]) * 17'(ib[5]) + 17'(ib[2]) * 17'(ib[7]);
          cres[1] = 17'(ib[1]) * 17'(ib[6]) + 17'(ib[2]) * 17'(ib[8]);
          cres[2] = 17'(ib[3]) * 17'(ib[5]) + 17'(ib[4]) * 17'(ib[7]);
          cres[3] = 17'(ib[3]) * 17'(ib[6]) + 17'(ib[4]) * 17'(ib[8]);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] r, a1, a2, a3, a4, b1, b2, b3, b4);
    ops[0] = r;  ops[1] = a1; ops[2] = a2; ops[3] = a3; ops[4] = a4;
    ops[5] = b1; ops[6] = b2; ops[7] = b3; ops[8] = b4;
  endtask

  function automatic logic [67:0] pack_ops();
    logic [67:0] j;
    j = '0;
    j[3:0] = ops[0][3:0];
    for (int i = 1; i < 9; i++) j[4 + 8 * (i - 1) +: 8] = ops[i];
    return j;
  endfunction

  task automatic wait_gnt(input string tag, input logic [1:0] exp, output int lat);
    lat = 0;
    while (bus.gnt == 2'b00 && lat < 60) begin
      tick();
      lat++;
    end
    check_eq({tag, "_gnt"}, bus.gnt, exp);
  endtask

  task automatic check_feed(input string tag);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), {bus.eng_in_valid, bus.eng_in}, {1'b1, ops[i]});
      if (i == 1) check_eq({tag, "_gnt_pulse"}, bus.gnt, 2'b00);
      tick();
    end
    check_eq({tag, "_feed_end"}, {bus.eng_in_valid, bus.eng_in}, 9'h000);
  endtask

  task automatic wait_res(input string tag, input logic id, input logic [67:0] c);
    int n = 0;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_res_valid"}, bus.res_valid, 1'b1);
    check_eq({tag, "_res_id"}, bus.res_id, id);
    check_eq({tag, "_res_c"}, bus.res_c, c);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    tick();
    check_eq({tag, "_res_clear"}, bus.res_valid, 1'b0);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat, n, gcount;
    logic seen;

    bus.req = 2'b00; bus.job0 = '0; bus.job1 = '0; bus.res_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_outs", {bus.gnt, bus.eng_in_valid, bus.eng_in, bus.res_valid, bus.res_id,
                          bus.busy, bus.err_timeout}, '0);
    check_eq("rst_res_c", bus.res_c, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // single job
    load_ops(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    @(negedge clk);
    bus.job0 = pack_ops();
    bus.req  = 2'b01;
    wait_gnt("t1", 2'b01, lat);
    check_eq("t1_gnt_lat", lat, 1);
    bus.req = 2'b00;
    check_feed("t1");
    wait_res("t1", 1'b0, C_T1);
    accept("t1");

    // tie and round-robin from a fresh pointer
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_ops(8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    bus.job0 = pack_ops();
    bus.job1 = pack_ops();
    bus.req  = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_gnt($sformatf("tie%0d", k), (k == 1) ? 2'b10 : 2'b01, lat);
      if (k == 2) bus.req = 2'b00;
      check_feed($sformatf("tie%0d", k));
      wait_res($sformatf("tie%0d", k), (k == 1), C_MAX);
      accept($sformatf("tie%0d", k));
    end

    // backpressure with requester 1 pending
    load_ops(8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6);
    @(negedge clk);
    bus.job0 = pack_ops();
    bus.req  = 2'b01;
    wait_gnt("bp0", 2'b01, lat);
    bus.req = 2'b00;
    check_feed("bp0");
    wait_res("bp0", 1'b0, C_ID);
    load_ops(8'd0, 8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    @(negedge clk);
    bus.job1 = pack_ops();
    bus.req  = 2'b10;
    gcount = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.gnt != 2'b00) gcount++;
      if (!bus.res_valid || bus.res_c !== C_ID) seen = 1'b1;
    end
    check_eq("bp_no_gnt", gcount, 0);
    check_eq("bp_unstable", seen, 1'b0);
    check_eq("bp_busy", bus.busy, 1'b1);
    accept("bp0");
    wait_gnt("bp1", 2'b10, lat);
    check_eq("bp1_gnt_lat", lat, GAP + 1);
    bus.req = 2'b00;
    check_feed("bp1");
    wait_res("bp1", 1'b1, C_X2);
    accept("bp1");

    // silent engine
    eng_mode = 1;
    load_ops(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    bus.job0 = pack_ops();
    bus.req  = 2'b01;
    wait_gnt("to", 2'b01, lat);
    bus.req = 2'b00;
    check_feed("to");
    n = 0;
    seen = 1'b0;
    while (!bus.err_timeout && n < 100) begin
      tick();
      n++;
      if (bus.res_valid) seen = 1'b1;
    end
    check_eq("to_lat", n, TIMEOUT);
    check_eq("to_nores", seen | bus.res_valid, 1'b0);
    tick();
    check_eq("to_pulse", bus.err_timeout, 1'b0);
    check_eq("to_busy_gap", bus.busy, 1'b1);
    tick();
    check_eq("to_busy_fall", bus.busy, 1'b0);

    // short burst, then a clean job
    eng_mode = 2;
    load_ops(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    @(negedge clk);
    bus.job0 = pack_ops();
    bus.req  = 2'b01;
    wait_gnt("sb", 2'b01, lat);
    bus.req = 2'b00;
    check_feed("sb");
    n = 0;
    seen = 1'b0;
    while (!bus.err_timeout && n < 100) begin
      tick();
      n++;
      if (bus.res_valid) seen = 1'b1;
    end
    check_eq("sb_err", bus.err_timeout, 1'b1);
    check_eq("sb_nores", seen, 1'b0);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check_eq("sb_idle", bus.busy, 1'b0);
    eng_mode = 0;
    load_ops(8'd0, 8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    @(negedge clk);
    bus.job1 = pack_ops();
    bus.req  = 2'b10;
    wait_gnt("sb2", 2'b10, lat);
    bus.req = 2'b00;
    check_feed("sb2");
    wait_res("sb2", 1'b1, C_X2);
    accept("sb2");

    // reset in the middle of a burst
    load_ops(8'd5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    @(negedge clk);
    bus.job0 = pack_ops();
    bus.req  = 2'b01;
    wait_gnt("rs0", 2'b01, lat);
    repeat (3) tick();
    check_eq("rs_byte4", {bus.eng_in_valid, bus.eng_in}, {1'b1, 8'd3});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rs_async", {bus.gnt, bus.eng_in_valid, bus.eng_in, bus.res_valid, bus.busy,
                          bus.err_timeout}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt("rs1", 2'b01, lat);
    bus.req = 2'b00;
    check_feed("rs1");
    wait_res("rs1", 1'b0, C_T1);
    accept("rs1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_job_sched.md
Name: mm_job_sched

Overview:
- Scheduler that shares one serial 2x2 matrix-multiply engine between two requesters.
- The engine takes a 9-byte input burst (rotate byte, a1..a4, b1..b4) and returns four 17-bit results (c0..c3) on consecutive out_valid cycles.
- This block does the following:
  - arbitrates round-robin between requesters;
  - serialises the granted job into the engine;
  - collects the four results and hands them back with a valid/ready handshake;
  - enforces an idle gap between jobs and a response timeout.

Parameters:
- TIMEOUT, 32, maximum cycles in WAIT before the job is aborted.
- GAP, 2, idle cycles forced after each job so the engine returns to idle.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  2  job request per requester; held high with stable job data until gnt
- job0  in  68  requester 0 job: [3:0] rot, [35:4] a (a1 at [11:4] ... a4 at [35:28]), [67:36] b (b1 at [43:36] ... b4 at [67:60])
- job1  in  68  requester 1 job, same packing
- gnt  out  2  one-hot, one-cycle pulse: job accepted and latched
- eng_in  out  8  byte to engine
- eng_in_valid  out  1  engine input strobe
- eng_out  in  17  engine result word
- eng_out_valid  in  1  engine result strobe
- res_valid  out  1  result available; held until accepted
- res_ready  in  1  requester accepts result
- res_id  out  1  requester index owning the result
- res_c  out  68  {c3,c2,c1,c0}, with c0 at [16:0]
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer set so requester 0 wins the first tie.
- All outputs are registered.
- States: IDLE, FEED, WAIT, COLLECT, RESP, GAP.
- IDLE:
  - If any req bit is sampled high, choose a winner. With both high, the winner is the requester not granted last; with one high, that one wins.
  - On the same edge: gnt[winner]=1 for one cycle, job latched, res_id set, pointer updated, go to FEED.
- FEED: 9 consecutive cycles with eng_in_valid=1. eng_in sequence is {4'b0,rot}, a1, a2, a3, a4, b1, b2, b3, b4. Then eng_in_valid=0, eng_in=0, go to WAIT.
- WAIT:
  - Timeout counter starts at 0.
  - On the first eng_out_valid, capture eng_out as c0 and go to COLLECT.
  - If the counter reaches TIMEOUT-1 without eng_out_valid: pulse err_timeout, discard the job, go to GAP.
- COLLECT:
  - Capture c1, c2, c3 on the next three cycles.
  - If eng_out_valid is low in any of these cycles: pulse err_timeout, discard, go to GAP.
  - After c3 is captured, set res_valid=1 and go to RESP.
- RESP:
  - res_valid, res_c and res_id are held stable.
  - When res_valid && res_ready: clear res_valid, go to GAP.
  - No new grant is issued while a result is pending (backpressure).
- GAP:
  - Count GAP cycles, then go to IDLE.
  - If eng_out_valid is seen in GAP, the counter restarts, so the engine's out_valid must be low for GAP cycles.
- Requests that arrive outside IDLE are not lost while req is held. They are arbitrated on return to IDLE.
- gnt is never asserted outside the IDLE-to-FEED edge.
- Results are not modified; width is passed through (17 bits per word; maximum value 2*255*255 = 130050).
- Reset mid-operation: everything returns to the reset state immediately. Any partial burst is abandoned and eng_in_valid drops asynchronously.

Decomposition:
- Shared package mm_pkg, containing:
  - state enum (IDLE..GAP);
  - JOB_BYTES=9, RES_WORDS=4, RES_W=17;
  - job-field offset constants (ROT_LSB, A_LSB, B_LSB).
- One sub-module, rr_arb2: 2-way round-robin picker (req, update strobe → one-hot winner), with the pointer registered inside.

Test Plan:
- Single job: req=01, job0 rot=0, a=1,2,3,4, b=5,6,7,8, engine model.
  - gnt=01 one cycle later.
  - eng_in bytes 00,01,02,03,04,05,06,07,08 on 9 consecutive cycles.
  - res_valid with res_id=0 and c0..c3 = 19, 22, 43, 50.
- Tie and round-robin: req=11 held, all operands 255, rot=0.
  - First gnt=01, then gnt=10.
  - Each result is 130050 x4 with the matching res_id.
  - A third tie grants requester 0 again.
- Backpressure: hold res_ready=0 for 20 cycles with req=10 pending.
  - res_valid and res_c stay stable, no gnt occurs.
  - After res_ready=1: GAP cycles pass, then gnt=10.
- Timeout: engine never asserts eng_out_valid.
  - err_timeout pulses exactly TIMEOUT cycles after FEED ends.
  - No res_valid; busy falls GAP cycles later.
- Short burst: engine asserts eng_out_valid for only 2 cycles.
  - err_timeout pulses, no result delivered.
  - The next job completes correctly.
- Reset in FEED: assert rst_n=0 after the 4th byte.
  - All outputs go to 0 immediately.
  - After release, req=01 restarts from the rot byte with gnt=01.
